ll_reservation_monitor: RTL and testbench
=========================================

// Module: ll_reservation_monitor
// PURPOSE
//  Multi-channel LL/SC reservation monitor; replaces the single-bit LLbit register.
//  - One link per channel (hardware context or LSU port). Each link holds a valid bit and a
//    granule address.
//  - A link is cleared by an exception flush, an SC, a snooped store to its granule, or the
//    livelock timeout.
//  - Sits beside the MEM/WB stage; sc_ok_o decides whether an SC writes memory.
// PARAMETERS
//  NUM_CH     2   number of independent reservation channels (>=1)
//  ADDR_W     32  physical address width
//  GRAN_LSB   4   low address bits ignored in compares (16-byte granule); 0 = exact byte
//  TIMEOUT    0   cycles a link may live before auto-clear; 0 = never times out
//  TMO_W      16  timeout counter width; TIMEOUT < 2**TMO_W
// PORTS
//  clk          in   1              clock, all state on rising edge
//  rst          in   1              synchronous, active-high reset
//  flush        in   NUM_CH         per-channel pipeline flush
//  flush_exc    in   NUM_CH         flush cause is exception (qualifies flush)
//  ll_req       in   NUM_CH         LL retiring on channel c
//  sc_req       in   NUM_CH         SC retiring on channel c
//  op_addr      in   NUM_CH*ADDR_W  LL/SC address, channel c at [c*ADDR_W +: ADDR_W]
//  snp_valid    in   1              a store, from any agent, commits this cycle
//  snp_addr     in   ADDR_W         address of that store
//  llbit_o      out  NUM_CH         link valid per channel (registered)
//  sc_ok_o      out  NUM_CH         SC success for channel c this cycle (combinational)
// BEHAVIOUR
//  Reset: all links invalid, all stored addresses 0, all timeout counters 0. Outputs
//  llbit_o = 0 and sc_ok_o = 0. rst has priority over every other input.
//  Per-channel state is IDLE (llbit=0) or LINKED (llbit=1).
//  Granule match: a[ADDR_W-1:GRAN_LSB] == b[ADDR_W-1:GRAN_LSB].
//  snp_hit[c] = snp_valid & LINKED[c] & granule match(link_addr[c], snp_addr).
//  sc_ok_o[c] = sc_req[c] & LINKED[c] & granule match(link_addr[c], op_addr[c]) & ~snp_hit[c]
//    & ~(flush[c] & flush_exc[c]).
//    - Zero latency. The store datapath samples it in the same cycle.
//  Next state per channel, evaluated in priority order:
//   1. flush[c] & flush_exc[c] -> IDLE. A flush that is not an exception leaves the link untouched.
//   2. sc_req[c] -> IDLE. An SC always consumes the link, whether it passes or fails. If sc_req
//      and ll_req are both high, the SC takes precedence and the LL is ignored.
//   3. ll_req[c] -> LINKED. Captures op_addr[c] and clears the counter. This also applies when
//      the channel is already LINKED (re-link to the new address). The LL wins over a
//      same-cycle snp_hit.
//   4. snp_hit[c] -> IDLE.
//   5. TIMEOUT != 0 and LINKED and cnt[c] == TIMEOUT-1 -> IDLE. The link lives for exactly
//      TIMEOUT cycles after the LL edge.
//   6. Otherwise hold. While LINKED, cnt increments by 1 per cycle; it is cleared on entry to IDLE.
//  A snoop is checked against every channel in parallel; one store can clear several links.
//  A channel's own store is presented on snp_* by the LSU and clears its own link (MIPS semantics).
//  cnt never wraps, because clear at TIMEOUT-1 occurs first; it is unused when TIMEOUT = 0.
//  The stored address is not cleared on leaving LINKED; only llbit gates its use.
//  An SC in IDLE gives sc_ok_o = 0 and causes no state change.
//  rst asserted mid-operation clears all links at the next edge, regardless of other inputs.
// TESTING
//  1. LL ch0 @0x1000; 3 cycles later SC ch0 @0x1008 (GRAN_LSB=4) -> sc_ok_o[0]=1;
//     llbit_o[0]=0 the next cycle.
//  2. LL ch0 @0x1000; snp_valid @0x100C; then SC ch0 @0x1000 -> llbit_o[0]=0 after the snoop;
//     sc_ok_o[0]=0.
//  3. LL ch0 @0x1000 and LL ch1 @0x2000; snoop @0x2004 -> only llbit_o[1] clears;
//     SC ch0 @0x1000 -> sc_ok_o[0]=1.
//  4. LL ch1 @0x40; flush[1]=1 with flush_exc[1]=0 -> still linked; flush_exc[1]=1 ->
//     llbit_o[1]=0; same-cycle SC -> sc_ok_o[1]=0.
//  5. TIMEOUT=8: LL ch0 at edge 0 -> llbit_o[0]=1 for edges 1..8, then 0 after edge 8;
//     an SC in cycle 8 fails.
//  6. Same cycle: snp @0x1000 + LL ch0 @0x1000 -> linked. Same cycle: snp @0x1000 +
//     SC ch0 @0x1000 while linked -> sc_ok_o[0]=0. rst during LINKED -> all llbit_o=0.

Source files
------------

// File: rtl/ll_reservation_monitor.sv
// Multi-channel LL/SC reservation monitor: one link (valid + granule address) per channel,
// cleared by exception flush, SC, a snooped store to the granule, or the livelock timeout.
module ll_reservation_monitor #(
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned GRAN_LSB = 4,
    parameter int unsigned TIMEOUT  = 0,
    parameter int unsigned TMO_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        flush,
    input  logic [NUM_CH-1:0]        flush_exc,
    input  logic [NUM_CH-1:0]        ll_req,
    input  logic [NUM_CH-1:0]        sc_req,
    input  logic [NUM_CH*ADDR_W-1:0] op_addr,
    input  logic                     snp_valid,
    input  logic [ADDR_W-1:0]        snp_addr,
    output logic [NUM_CH-1:0]        llbit_o,
    output logic [NUM_CH-1:0]        sc_ok_o
);

    typedef enum logic {StIdle, StLinked} state_e;

    // Masked XOR compare keeps every address bit in use and handles GRAN_LSB = 0.
    localparam logic [ADDR_W-1:0] GranMask = {ADDR_W{1'b1}} << GRAN_LSB;
    localparam logic [TMO_W-1:0]  TmoLast  = TMO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam bit                TmoEn    = (TIMEOUT != 0);

    state_e            state_q [NUM_CH];
    logic [ADDR_W-1:0] addr_q  [NUM_CH];
    logic [TMO_W-1:0]  cnt_q   [NUM_CH];

    logic [NUM_CH-1:0] linked;
    logic [NUM_CH-1:0] snp_hit;
    logic [NUM_CH-1:0] op_match;
    logic [NUM_CH-1:0] exc_flush;
    logic [NUM_CH-1:0] tmo_hit;

    always_comb begin
        linked    = '0;
        snp_hit   = '0;
        op_match  = '0;
        exc_flush = '0;
        tmo_hit   = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            linked[c]    = (state_q[c] == StLinked);
            snp_hit[c]   = snp_valid && linked[c] &&
                           (((addr_q[c] ^ snp_addr) & GranMask) == '0);
            op_match[c]  = (((addr_q[c] ^ op_addr[c*ADDR_W +: ADDR_W]) & GranMask) == '0);
            exc_flush[c] = flush[c] && flush_exc[c];
            tmo_hit[c]   = TmoEn && linked[c] && (cnt_q[c] == TmoLast);
        end
    end

    always_comb begin
        llbit_o = linked;
        sc_ok_o = sc_req & linked & op_match & ~snp_hit & ~exc_flush;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                state_q[c] <= StIdle;
                addr_q[c]  <= '0;
                cnt_q[c]   <= '0;
            end
        end else begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (exc_flush[c] || sc_req[c]) begin
                    state_q[c] <= StIdle;
                    cnt_q[c]   <= '0;
                end else if (ll_req[c]) begin
                    // LL beats a same-cycle snoop and re-links an already linked channel.
                    state_q[c] <= StLinked;
                    addr_q[c]  <= op_addr[c*ADDR_W +: ADDR_W];
                    cnt_q[c]   <= '0;
                end else if (snp_hit[c] || tmo_hit[c]) begin
                    state_q[c] <= StIdle;
                    cnt_q[c]   <= '0;
                end else if (TmoEn && linked[c]) begin
                    cnt_q[c] <= cnt_q[c] + TMO_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ll_reservation_monitor.sv
// Directed bench for ll_reservation_monitor: a TIMEOUT=8 and a TIMEOUT=0 instance share stimulus;
// expected outputs are queued as each step is driven and compared mid-cycle.
module tb_ll_reservation_monitor;

    localparam int unsigned NCH = 2;
    localparam int unsigned AW  = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [NCH-1:0]  flush, flush_exc, ll_req, sc_req;
    logic [NCH*AW-1:0] op_addr;
    logic            snp_valid;
    logic [AW-1:0]   snp_addr;
    logic [NCH-1:0]  llbit_t, sc_ok_t, llbit_n, sc_ok_n;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [1:0] ll_t;
        logic [1:0] ok_t;
        logic [1:0] ll_n;
        logic [1:0] ok_n;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    ll_reservation_monitor #(
        .NUM_CH(NCH), .ADDR_W(AW), .GRAN_LSB(4), .TIMEOUT(8), .TMO_W(16)
    ) dut_t (
        .clk(clk), .rst(rst), .flush(flush), .flush_exc(flush_exc), .ll_req(ll_req),
        .sc_req(sc_req), .op_addr(op_addr), .snp_valid(snp_valid), .snp_addr(snp_addr),
        .llbit_o(llbit_t), .sc_ok_o(sc_ok_t)
    );

    ll_reservation_monitor #(
        .NUM_CH(NCH), .ADDR_W(AW), .GRAN_LSB(4), .TIMEOUT(0), .TMO_W(16)
    ) dut_n (
        .clk(clk), .rst(rst), .flush(flush), .flush_exc(flush_exc), .ll_req(ll_req),
        .sc_req(sc_req), .op_addr(op_addr), .snp_valid(snp_valid), .snp_addr(snp_addr),
        .llbit_o(llbit_n), .sc_ok_o(sc_ok_n)
    );

    task automatic drive(input logic [1:0] ll, input logic [1:0] sc, input logic [1:0] fl,
                         input logic [1:0] fe, input logic [31:0] a0, input logic [31:0] a1,
                         input logic sv, input logic [31:0] sa);
        ll_req    = ll;
        sc_req    = sc;
        flush     = fl;
        flush_exc = fe;
        op_addr   = {a1, a0};
        snp_valid = sv;
        snp_addr  = sa;
    endtask

    task automatic idle();
        drive(2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic expect_split(input string tag, input logic [1:0] ll_t, input logic [1:0] ok_t,
                                input logic [1:0] ll_n, input logic [1:0] ok_n);
        exp_t e;
        e.tag  = tag;
        e.ll_t = ll_t;
        e.ok_t = ok_t;
        e.ll_n = ll_n;
        e.ok_n = ok_n;
        sb.push_back(e);
    endtask

    task automatic expect_both(input string tag, input logic [1:0] ll, input logic [1:0] ok);
        expect_split(tag, ll, ok, ll, ok);
    endtask

    task automatic check(input string tag, input string what, input logic [1:0] got,
                         input logic [1:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s/%s: observed %b expected %b", tag, what, got, exp);
        end
    endtask

    // Compare mid-cycle, then advance past the next rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
        end else begin
            e = sb.pop_front();
            check(e.tag, "llbit_t", llbit_t, e.ll_t);
            check(e.tag, "sc_ok_t", sc_ok_t, e.ok_t);
            check(e.tag, "llbit_n", llbit_n, e.ll_n);
            check(e.tag, "sc_ok_n", sc_ok_n, e.ok_n);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed time limit expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        idle();
        @(posedge clk);
        #1;
        drive(2'b11, 2'b11, 2'b00, 2'b00, 32'h1000, 32'h2000, 1'b1, 32'h1000);
        expect_both("reset", 2'b00, 2'b00); tick();
        idle();
        expect_both("reset_hold", 2'b00, 2'b00); tick();
        rst = 1'b0;

        // SC in IDLE fails and changes nothing
        drive(2'b00, 2'b01, 2'b00, 2'b00, 32'h1000, 32'h0, 1'b0, 32'h0);
        expect_both("sc_idle", 2'b00, 2'b00); tick();

        // 1: LL, wait, SC to another byte of the same granule
        drive(2'b01, 2'b00, 2'b00, 2'b00, 32'h1000, 32'h0, 1'b0, 32'h0);
        expect_both("t1_ll", 2'b00, 2'b00); tick();
        idle();
        expect_both("t1_w1", 2'b01, 2'b00); tick();
        expect_both("t1_w2", 2'b01, 2'b00); tick();
        expect_both("t1_w3", 2'b01, 2'b00); tick();
        drive(2'b00, 2'b01, 2'b00, 2'b00, 32'h1008, 32'h0, 1'b0, 32'h0);
        expect_both("t1_sc", 2'b01, 2'b01); tick();
        idle();
        expect_both("t1_after", 2'b00, 2'b00); tick();

        // SC to the next granule fails but still consumes the link
        drive(2'b01, 2'b00, 2'b00, 2'b00, 32'h1000, 32'h0, 1'b0, 32'h0);
        expect_both("gran_ll", 2'b00, 2'b00); tick();
        drive(2'b00, 2'b01, 2'b00, 2'b00, 32'h1010, 32'h0, 1'b0, 32'h0);
        expect_both("gran_sc", 2'b01, 2'b00); tick();
        idle();
        expect_both("gran_after", 2'b00, 2'b00); tick();

        // 2: snoop to the granule kills the link
        drive(2'b01, 2'b00, 2'b00, 2'b00, 32'h1000, 32'h0, 1'b0, 32'h0);
        expect_both("t2_ll", 2'b00, 2'b00); tick();
        drive(2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 32'h100C);
        expect_both("t2_snp", 2'b01, 2'b00); tick();
        drive(2'b00, 2'b01, 2'b00, 2'b00, 32'h1000, 32'h0, 1'b0, 32'h0);
        expect_both("t2_sc", 2'b00, 2'b00); tick();

        // 3: snoop clears only the matching channel
        drive(2'b11, 2'b00, 2'b00, 2'b00, 32'h1000, 32'h2000, 1'b0, 32'h0);
        expect_both("t3_ll", 2'b00, 2'b00); tick();
        drive(2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 32'h2004);
        expect_both("t3_snp", 2'b11, 2'b00); tick();
        drive(2'b00, 2'b01, 2'b00, 2'b00, 32'h1000, 32'h0, 1'b0, 32'h0);
        expect_both("t3_sc", 2'b01, 2'b01); tick();
        idle();
        expect_both("t3_after", 2'b00, 2'b00); tick();

        // 4: non-exception flush is ignored; exception flush clears and blocks SC
        drive(2'b10, 2'b00, 2'b00, 2'b00, 32'h0, 32'h40, 1'b0, 32'h0);
        expect_both("t4_ll", 2'b00, 2'b00); tick();
        drive(2'b00, 2'b00, 2'b10, 2'b00, 32'h0, 32'h40, 1'b0, 32'h0);
        expect_both("t4_flush", 2'b10, 2'b00); tick();
        drive(2'b00, 2'b10, 2'b10, 2'b10, 32'h0, 32'h40, 1'b0, 32'h0);
        expect_both("t4_exc", 2'b10, 2'b00); tick();
        idle();
        expect_both("t4_after", 2'b00, 2'b00); tick();

        // SC and LL together: SC wins and the LL is dropped
        drive(2'b10, 2'b00, 2'b00, 2'b00, 32'h0, 32'h40, 1'b0, 32'h0);
        expect_both("scll_ll", 2'b00, 2'b00); tick();
        drive(2'b10, 2'b10, 2'b00, 2'b00, 32'h0, 32'h40, 1'b0, 32'h0);
        expect_both("scll_both", 2'b10, 2'b10); tick();
        idle();
        expect_both("scll_after", 2'b00, 2'b00); tick();

        // Re-link moves the reservation to the new address
        drive(2'b01, 2'b00, 2'b00, 2'b00, 32'h1000, 32'h0, 1'b0, 32'h0);
        expect_both("relink_1", 2'b00, 2'b00); tick();
        drive(2'b01, 2'b00, 2'b00, 2'b00, 32'h3000, 32'h0, 1'b0, 32'h0);
        expect_both("relink_2", 2'b01, 2'b00); tick();
        drive(2'b00, 2'b01, 2'b00, 2'b00, 32'h1000, 32'h0, 1'b0, 32'h0);
        expect_both("relink_sc", 2'b01, 2'b00); tick();

        // 5: timeout after exactly 8 cycles on dut_t; dut_n keeps the link
        drive(2'b01, 2'b00, 2'b00, 2'b00, 32'h1000, 32'h0, 1'b0, 32'h0);
        expect_both("t5_ll", 2'b00, 2'b00); tick();
        idle();
        for (int k = 1; k <= 8; k++) begin
            expect_both($sformatf("t5_live%0d", k), 2'b01, 2'b00); tick();
        end
        drive(2'b00, 2'b01, 2'b00, 2'b00, 32'h1000, 32'h0, 1'b0, 32'h0);
        expect_split("t5_expired", 2'b00, 2'b00, 2'b01, 2'b01); tick();
        idle();
        expect_both("t5_after", 2'b00, 2'b00); tick();

        // 6: LL beats same-cycle snoop; snoop blocks same-cycle SC; reset clears all
        drive(2'b01, 2'b00, 2'b00, 2'b00, 32'h1000, 32'h0, 1'b1, 32'h1000);
        expect_both("t6_ll_snp", 2'b00, 2'b00); tick();
        idle();
        expect_both("t6_linked", 2'b01, 2'b00); tick();
        drive(2'b00, 2'b01, 2'b00, 2'b00, 32'h1000, 32'h0, 1'b1, 32'h1000);
        expect_both("t6_sc_snp", 2'b01, 2'b00); tick();
        drive(2'b11, 2'b00, 2'b00, 2'b00, 32'h1000, 32'h2000, 1'b0, 32'h0);
        expect_both("t6_ll2", 2'b00, 2'b00); tick();
        rst = 1'b1;
        expect_both("t6_rst", 2'b11, 2'b00); tick();
        rst = 1'b0;
        idle();
        expect_both("t6_after_rst", 2'b00, 2'b00); tick();

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_drain: observed %0d left expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
